toggle_req_gen: RTL and testbench

Upstream driver for the toggle flip-flop stage. It takes a raw, bouncing push-button level and synchronises and debounces it. It produces registered single-cycle toggle pulses (`t_out`) that connect directly to the T input of the T flip-flop. Holding the button auto-repeats the pulses, and a pulse counter is exposed for status and debug.

---
 rtl/toggle_req_gen.sv | 129 ++++++++++++
 tb/tb_toggle_req_gen.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_req_gen.sv
// toggle_req_gen: turns a raw, bouncing push-button level into single-cycle T pulses.
// Path: two-flop synchroniser -> debouncer -> press/hold/auto-repeat FSM.
// The FSM fires a registered pulse on press and again while the button is held.
// Each emitted pulse is also counted in pulse_cnt.
module toggle_req_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 8,
    parameter int unsigned REPEAT_PERIOD   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    input  logic       enable,
    output logic       t_out,
    output logic       btn_level,
    output logic [7:0] pulse_cnt
);

    localparam int unsigned DW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HCNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                      : REPEAT_PERIOD;
    localparam int unsigned HW       = $clog2(HCNT_MAX + 1);

    localparam logic [DW-1:0] DCNT_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    // A zero delay disables auto-repeat, so its terminal value is never consulted.
    localparam logic [HW-1:0] DELAY_LAST  = HW'((REPEAT_DELAY != 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);
    localparam bit            REPEAT_EN   = (REPEAT_DELAY != 0);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HELD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic          s1;
    logic          s2;
    logic [DW-1:0] dcnt;
    logic [1:0]    state;
    logic [1:0]    state_d;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_d;
    logic          fire;
    logic          emit;

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    // Debouncer: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt      <= '0;
            btn_level <= 1'b0;
        end else if (s2 == btn_level) begin
            dcnt <= '0;
        end else if (dcnt == DCNT_LAST) begin
            btn_level <= s2;
            dcnt      <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    // Press / hold / repeat scheduling; a low level always wins over a terminal count.
    always_comb begin
        state_d = state;
        hcnt_d  = hcnt;
        fire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (btn_level) begin
                    fire    = 1'b1;
                    state_d = ST_HELD;
                    hcnt_d  = '0;
                end
            end
            ST_HELD: begin
                if (!btn_level) begin
                    state_d = ST_IDLE;
                end else if (REPEAT_EN && (hcnt == DELAY_LAST)) begin
                    fire    = 1'b1;
                    state_d = ST_REPEAT;
                    hcnt_d  = '0;
                end else begin
                    hcnt_d = hcnt + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!btn_level) begin
                    state_d = ST_IDLE;
                end else if (hcnt == PERIOD_LAST) begin
                    fire   = 1'b1;
                    hcnt_d = '0;
                end else begin
                    hcnt_d = hcnt + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hcnt_d  = '0;
            end
        endcase
    end

    // A fire while disabled is dropped, never deferred.
    assign emit = fire & enable;

    // FSM state, registered pulse output and pulse counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            hcnt      <= '0;
            t_out     <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            state     <= state_d;
            hcnt      <= hcnt_d;
            t_out     <= emit;
            pulse_cnt <= pulse_cnt + {7'd0, emit};
        end
    end

endmodule

// File: tb/tb_toggle_req_gen.sv
// tb_toggle_req_gen: scenario tasks compared against a timing-rule reference model.
module tb_toggle_req_gen;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 4;

    logic       clk;
    logic       rst;
    logic       btn_in;
    logic       enable;
    logic       t_out;
    logic       btn_level;
    logic [7:0] pulse_cnt;

    int total = 0;
    int bad   = 0;

    toggle_req_gen #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .enable    (enable),
        .t_out     (t_out),
        .btn_level (btn_level),
        .pulse_cnt (pulse_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: delay line, sample-history debounce, and pulse times from rise edge.
    int         m_edge = 0;
    int         m_rise = 0;
    bit         m_s1   = 1'b0;
    bit         m_s2   = 1'b0;
    bit         m_lvl  = 1'b0;
    bit         m_t    = 1'b0;
    logic [7:0] m_cnt  = 8'd0;
    bit         hist[$];

    task automatic model_edge();
        bit old_lvl;
        bit old_s2;
        bit fire;
        bit all_diff;
        int k;
        m_edge++;
        if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_t = 1'b0; m_cnt = 8'd0;
            m_rise = 0;
            hist.delete();
            return;
        end
        old_lvl = m_lvl;
        old_s2  = m_s2;
        fire    = 1'b0;
        if (old_lvl) begin
            k    = m_edge - m_rise;
            fire = (k == 1) || (RD != 0 && k >= 1 + RD && ((k - 1 - RD) % RP) == 0);
        end
        m_t = fire && enable;
        if (m_t) m_cnt = m_cnt + 8'd1;
        hist.push_back(old_s2);
        if (hist.size() > DB) void'(hist.pop_front());
        all_diff = (hist.size() == DB);
        foreach (hist[i]) if (hist[i] == old_lvl) all_diff = 1'b0;
        if (all_diff) begin
            m_lvl = !old_lvl;
            if (m_lvl) m_rise = m_edge;
        end
        m_s2 = m_s1;
        m_s1 = btn_in;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic settle(input int n);
        btn_in = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_in = 1'b1; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (t_out !== 1'b0 || btn_level !== 1'b0 || pulse_cnt !== 8'd0) begin
                bad++;
                $display("FAIL reset_hold got %b/%b/%0d want 0/0/0", t_out, btn_level, pulse_cnt);
            end
        end
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            total++;
            if (btn_level !== (e >= 6) || t_out !== (e == 7)) begin
                bad++;
                $display("FAIL reset_release edge=%0d got lvl=%b t=%b want lvl=%b t=%b",
                         e, btn_level, t_out, e >= 6, e == 7);
            end
        end
        settle(12);
    endtask

    task automatic test_clean_press();
        logic [7:0] cnt0;
        settle(4);
        cnt0 = m_cnt;
        for (int e = 1; e <= 22; e++) begin
            btn_in = (e <= 8);
            step();
            total++;
            if (btn_level !== (e >= 6 && e < 14) || t_out !== (e == 7)) begin
                bad++;
                $display("FAIL clean_press edge=%0d got lvl=%b t=%b want lvl=%b t=%b",
                         e, btn_level, t_out, e >= 6 && e < 14, e == 7);
            end
            total++;
            if ({t_out, btn_level, pulse_cnt} !== {m_t, m_lvl, m_cnt}) begin
                bad++;
                $display("FAIL clean_press_model edge=%0d got %b/%b/%0d want %b/%b/%0d",
                         e, t_out, btn_level, pulse_cnt, m_t, m_lvl, m_cnt);
            end
        end
        total++;
        if (pulse_cnt !== cnt0 + 8'd1) begin
            bad++;
            $display("FAIL clean_press_cnt got %0d want %0d", pulse_cnt, cnt0 + 8'd1);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] cnt0;
        int         pulses;
        settle(4);
        cnt0   = m_cnt;
        pulses = 0;
        for (int e = 1; e <= 34; e++) begin
            btn_in = (e <= 10) ? e[0] : (e <= 18);
            step();
            if (t_out === 1'b1) pulses++;
            total++;
            if ({t_out, btn_level, pulse_cnt} !== {m_t, m_lvl, m_cnt}) begin
                bad++;
                $display("FAIL bounce_model edge=%0d got %b/%b/%0d want %b/%b/%0d",
                         e, t_out, btn_level, pulse_cnt, m_t, m_lvl, m_cnt);
            end
        end
        total++;
        if (pulses != 1 || pulse_cnt !== cnt0 + 8'd1) begin
            bad++;
            $display("FAIL bounce_count got pulses=%0d cnt=%0d want 1 and %0d",
                     pulses, pulse_cnt, cnt0 + 8'd1);
        end
        settle(4);
        for (int e = 1; e <= 14; e++) begin
            btn_in = (e <= 3);
            step();
            total++;
            if (btn_level !== 1'b0 || t_out !== 1'b0) begin
                bad++;
                $display("FAIL glitch edge=%0d got lvl=%b t=%b want 0/0", e, btn_level, t_out);
            end
        end
    endtask

    task automatic test_auto_repeat();
        logic [7:0] cnt0;
        logic       exp_t;
        settle(4);
        cnt0 = m_cnt;
        // Level falls at E+24 so the E+25 terminal count sees a released button.
        for (int e = 1; e <= 40; e++) begin
            btn_in = (e <= 24);
            step();
            exp_t = (e == 7 || e == 15 || e == 19 || e == 23 || e == 27);
            total++;
            if (t_out !== exp_t || btn_level !== (e >= 6 && e < 30)) begin
                bad++;
                $display("FAIL auto_repeat edge=%0d got t=%b lvl=%b want t=%b lvl=%b",
                         e, t_out, btn_level, exp_t, e >= 6 && e < 30);
            end
        end
        total++;
        if (pulse_cnt !== cnt0 + 8'd5) begin
            bad++;
            $display("FAIL auto_repeat_cnt got %0d want %0d", pulse_cnt, cnt0 + 8'd5);
        end
    endtask

    task automatic test_enable_gating();
        logic [7:0] cnt0;
        logic       exp_t;
        settle(4);
        cnt0 = m_cnt;
        for (int e = 1; e <= 32; e++) begin
            btn_in = (e <= 20);
            enable = (e >= 11);
            step();
            exp_t = (e == 15 || e == 19 || e == 23);
            total++;
            if (t_out !== exp_t || btn_level !== (e >= 6 && e < 26)) begin
                bad++;
                $display("FAIL enable_gating edge=%0d got t=%b lvl=%b want t=%b lvl=%b",
                         e, t_out, btn_level, exp_t, e >= 6 && e < 26);
            end
            if (e == 14) begin
                total++;
                if (pulse_cnt !== cnt0) begin
                    bad++;
                    $display("FAIL enable_gating_hold got %0d want %0d", pulse_cnt, cnt0);
                end
            end
        end
        total++;
        if (pulse_cnt !== cnt0 + 8'd3) begin
            bad++;
            $display("FAIL enable_gating_cnt got %0d want %0d", pulse_cnt, cnt0 + 8'd3);
        end
        enable = 1'b1;
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int p = 1; p <= 256; p++) begin
            for (int e = 1; e <= 18; e++) begin
                btn_in = (e <= 8);
                step();
                total++;
                if ({t_out, btn_level, pulse_cnt} !== {m_t, m_lvl, m_cnt}) begin
                    bad++;
                    $display("FAIL wrap_model press=%0d edge=%0d got %b/%b/%0d want %b/%b/%0d",
                             p, e, t_out, btn_level, pulse_cnt, m_t, m_lvl, m_cnt);
                end
            end
            if (p == 255 || p == 256) begin
                total++;
                if (pulse_cnt !== ((p == 255) ? 8'd255 : 8'd0)) begin
                    bad++;
                    $display("FAIL wrap_cnt press=%0d got %0d want %0d",
                             p, pulse_cnt, (p == 255) ? 255 : 0);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        settle(4);
        btn_in = 1'b1;
        for (int e = 1; e <= 20; e++) step();
        rst = 1'b1;
        step();
        total++;
        if (t_out !== 1'b0 || pulse_cnt !== 8'd0 || btn_level !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got %b/%b/%0d want 0/0/0", t_out, btn_level, pulse_cnt);
        end
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
            total++;
            if (btn_level !== (e >= 6) || t_out !== (e == 7) || pulse_cnt !== ((e >= 7) ? 8'd1 : 8'd0)) begin
                bad++;
                $display("FAIL mid_reset_release edge=%0d got %b/%b/%0d", e, t_out, btn_level, pulse_cnt);
            end
        end
        settle(12);
    endtask

    task automatic test_random();
        int run;
        run = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run == 0) begin
                btn_in = ~btn_in;
                run    = $urandom_range(1, 30);
            end
            run--;
            enable = ($urandom_range(0, 9) != 0);
            rst    = ($urandom_range(0, 399) == 0);
            step();
            total++;
            if ({t_out, btn_level, pulse_cnt} !== {m_t, m_lvl, m_cnt}) begin
                bad++;
                $display("FAIL random_model cyc=%0d got %b/%b/%0d want %b/%b/%0d",
                         c, t_out, btn_level, pulse_cnt, m_t, m_lvl, m_cnt);
            end
        end
        rst    = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 1'b1;
        enable = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_enable_gating();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
